// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I core: ID/EX register, forwarding muxes,
// ALU and EX/MEM register with bubble handling.

`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b001
`endif
`ifndef ALU_AND
`define ALU_AND 3'b010
`endif
`ifndef ALU_OR
`define ALU_OR  3'b011
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'b100
`endif

module execute_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  STALL,
  input  logic                  FLUSH,
  input  logic                  ID_VALID,
  input  logic [2:0]            ALU_CONTROL,
  input  logic                  ALU_SRC,
  input  logic [XLEN-1:0]       RS1_DATA,
  input  logic [XLEN-1:0]       RS2_DATA,
  input  logic [XLEN-1:0]       IMM,
  input  logic [REG_ADDR_W-1:0] RD,
  input  logic                  REG_WRITE,
  input  logic                  MEM_WRITE,
  input  logic                  MEM_TO_REG,
  input  logic [1:0]            FWD_A,
  input  logic [1:0]            FWD_B,
  input  logic [XLEN-1:0]       WB_DATA,
  output logic [XLEN-1:0]       EX_ALU_RESULT,
  output logic [XLEN-1:0]       EX_STORE_DATA,
  output logic [REG_ADDR_W-1:0] EX_RD,
  output logic                  EX_REG_WRITE,
  output logic                  EX_MEM_WRITE,
  output logic                  EX_MEM_TO_REG,
  output logic                  EX_VALID,
  output logic                  EX_ZERO
);

  logic                  ie_valid;
  logic [2:0]            ie_alu_control;
  logic                  ie_alu_src;
  logic [XLEN-1:0]       ie_rs1;
  logic [XLEN-1:0]       ie_rs2;
  logic [XLEN-1:0]       ie_imm;
  logic [REG_ADDR_W-1:0] ie_rd;
  logic                  ie_reg_write;
  logic                  ie_mem_write;
  logic                  ie_mem_to_reg;
  logic [1:0]            ie_fwd_a;
  logic [1:0]            ie_fwd_b;

  logic                  take;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       fb;
  logic [XLEN-1:0]       op_b;
  logic [XLEN-1:0]       alu_result;

  assign take = ID_VALID & ~FLUSH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_valid       <= 1'b0;
      ie_alu_control <= '0;
      ie_alu_src     <= 1'b0;
      ie_rs1         <= '0;
      ie_rs2         <= '0;
      ie_imm         <= '0;
      ie_rd          <= '0;
      ie_reg_write   <= 1'b0;
      ie_mem_write   <= 1'b0;
      ie_mem_to_reg  <= 1'b0;
      ie_fwd_a       <= '0;
      ie_fwd_b       <= '0;
    end else if (!STALL) begin
      ie_valid       <= take;
      ie_alu_control <= ALU_CONTROL;
      ie_alu_src     <= ALU_SRC;
      ie_rs1         <= RS1_DATA;
      ie_rs2         <= RS2_DATA;
      ie_imm         <= IMM;
      ie_rd          <= RD;
      ie_reg_write   <= REG_WRITE & take;
      ie_mem_write   <= MEM_WRITE & take;
      ie_mem_to_reg  <= MEM_TO_REG;
      ie_fwd_a       <= FWD_A;
      ie_fwd_b       <= FWD_B;
    end
  end

  // Forward select 2'b11 falls back to the ID/EX copy.
  always_comb begin
    op_a = ie_rs1;
    case (ie_fwd_a)
      2'b01:   op_a = EX_ALU_RESULT;
      2'b10:   op_a = WB_DATA;
      default: op_a = ie_rs1;
    endcase
    fb = ie_rs2;
    case (ie_fwd_b)
      2'b01:   fb = EX_ALU_RESULT;
      2'b10:   fb = WB_DATA;
      default: fb = ie_rs2;
    endcase
    op_b = ie_alu_src ? ie_imm : fb;
  end

  always_comb begin
    alu_result = op_a + op_b;
    case (ie_alu_control)
      `ALU_SUB: alu_result = op_a - op_b;
      `ALU_AND: alu_result = op_a & op_b;
      `ALU_OR:  alu_result = op_a | op_b;
      `ALU_XOR: alu_result = op_a ^ op_b;
      default:  alu_result = op_a + op_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_ALU_RESULT <= '0;
      EX_STORE_DATA <= '0;
      EX_RD         <= '0;
      EX_REG_WRITE  <= 1'b0;
      EX_MEM_WRITE  <= 1'b0;
      EX_MEM_TO_REG <= 1'b0;
      EX_VALID      <= 1'b0;
      EX_ZERO       <= 1'b0;
    end else if (!STALL) begin
      EX_ALU_RESULT <= alu_result;
      EX_STORE_DATA <= fb;
      EX_RD         <= ie_rd;
      EX_REG_WRITE  <= ie_reg_write & ie_valid;
      EX_MEM_WRITE  <= ie_mem_write & ie_valid;
      EX_MEM_TO_REG <= ie_mem_to_reg;
      EX_VALID      <= ie_valid;
      EX_ZERO       <= (alu_result == '0);
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, forwarding,
// stall, flush and asynchronous reset.

module tb_execute_stage;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  logic        clk;
  logic        rst_n;
  logic        STALL, FLUSH, ID_VALID, ALU_SRC;
  logic [2:0]  ALU_CONTROL;
  logic [31:0] RS1_DATA, RS2_DATA, IMM, WB_DATA;
  logic [4:0]  RD;
  logic        REG_WRITE, MEM_WRITE, MEM_TO_REG;
  logic [1:0]  FWD_A, FWD_B;
  logic [31:0] EX_ALU_RESULT, EX_STORE_DATA;
  logic [4:0]  EX_RD;
  logic        EX_REG_WRITE, EX_MEM_WRITE, EX_MEM_TO_REG, EX_VALID, EX_ZERO;

  int n_total = 0;
  int n_fail  = 0;

  execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
    .ALU_CONTROL(ALU_CONTROL), .ALU_SRC(ALU_SRC), .RS1_DATA(RS1_DATA),
    .RS2_DATA(RS2_DATA), .IMM(IMM), .RD(RD), .REG_WRITE(REG_WRITE),
    .MEM_WRITE(MEM_WRITE), .MEM_TO_REG(MEM_TO_REG), .FWD_A(FWD_A), .FWD_B(FWD_B),
    .WB_DATA(WB_DATA), .EX_ALU_RESULT(EX_ALU_RESULT), .EX_STORE_DATA(EX_STORE_DATA),
    .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_WRITE(EX_MEM_WRITE),
    .EX_MEM_TO_REG(EX_MEM_TO_REG), .EX_VALID(EX_VALID), .EX_ZERO(EX_ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_VALID = 1'b0; ALU_CONTROL = OP_ADD; ALU_SRC = 1'b0;
    RS1_DATA = '0; RS2_DATA = '0; IMM = '0; RD = '0;
    REG_WRITE = 1'b0; MEM_WRITE = 1'b0; MEM_TO_REG = 1'b0;
    FWD_A = 2'b00; FWD_B = 2'b00;
  endtask

  task automatic drive(input logic [2:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic [1:0] fa, input logic [1:0] fbs);
    ID_VALID = 1'b1; ALU_CONTROL = op; ALU_SRC = src;
    RS1_DATA = a; RS2_DATA = b; IMM = imm; RD = rd;
    REG_WRITE = rw; MEM_WRITE = mw; MEM_TO_REG = 1'b0;
    FWD_A = fa; FWD_B = fbs;
  endtask

  // Present one instruction, then a bubble, so it lands on EX_* after two edges.
  task automatic run_one(input logic [2:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
    drive(op, src, a, b, imm, 5'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    idle();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res"},  EX_ALU_RESULT, 32'h0);
    chk({tag, "_st"},   EX_STORE_DATA, 32'h0);
    chk({tag, "_rd"},   {27'h0, EX_RD}, 32'h0);
    chk({tag, "_ctl"},  {27'h0, EX_REG_WRITE, EX_MEM_WRITE, EX_MEM_TO_REG, EX_VALID, EX_ZERO}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; STALL = 1'b0; FLUSH = 1'b0; WB_DATA = '0;
    idle();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(OP_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    idle();
    chk("add_latency_valid", {31'h0, EX_VALID}, 32'h0);
    tick();
    chk("add_res",   EX_ALU_RESULT, 32'd12);
    chk("add_rd",    {27'h0, EX_RD}, 32'd3);
    chk("add_rw",    {31'h0, EX_REG_WRITE}, 32'h1);
    chk("add_valid", {31'h0, EX_VALID}, 32'h1);
    chk("add_zero",  {31'h0, EX_ZERO}, 32'h0);

    run_one(OP_SUB, 1'b0, 32'd4, 32'd4, 32'd0);
    chk("sub_eq_res",  EX_ALU_RESULT, 32'h0);
    chk("sub_eq_zero", {31'h0, EX_ZERO}, 32'h1);
    run_one(OP_SUB, 1'b0, 32'd0, 32'd1, 32'd0);
    chk("sub_wrap_res",  EX_ALU_RESULT, 32'hFFFF_FFFF);
    chk("sub_wrap_zero", {31'h0, EX_ZERO}, 32'h0);
    run_one(OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'd55, 32'd1);
    chk("add_imm_wrap", EX_ALU_RESULT, 32'h0);
    chk("add_imm_st",   EX_STORE_DATA, 32'd55);
    run_one(OP_AND, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
    chk("and_res", EX_ALU_RESULT, 32'h00F0_00F0);
    run_one(OP_OR, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
    chk("or_res", EX_ALU_RESULT, 32'hFFF0_FFF0);
    run_one(OP_XOR, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
    chk("xor_res", EX_ALU_RESULT, 32'hFF00_FF00);
    run_one(3'b111, 1'b0, 32'd2, 32'd3, 32'd0);
    chk("default_add", EX_ALU_RESULT, 32'd5);

    drive(OP_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    drive(OP_ADD, 1'b0, 32'd99, 32'd1, 32'd0, 5'd4, 1'b1, 1'b0, 2'b01, 2'b00);
    tick();
    idle();
    chk("fwd_producer", EX_ALU_RESULT, 32'd12);
    tick();
    chk("fwd_a_exmem", EX_ALU_RESULT, 32'd13);
    chk("fwd_a_rd",    {27'h0, EX_RD}, 32'd4);

    WB_DATA = 32'd40;
    drive(OP_ADD, 1'b0, 32'd1, 32'd5, 32'd0, 5'd6, 1'b1, 1'b0, 2'b00, 2'b10);
    tick();
    idle();
    tick();
    chk("fwd_b_store", EX_STORE_DATA, 32'd40);
    chk("fwd_b_res",   EX_ALU_RESULT, 32'd41);
    WB_DATA = 32'd0;

    drive(OP_ADD, 1'b0, 32'd2, 32'd3, 32'd0, 5'd7, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    drive(OP_ADD, 1'b0, 32'd10, 32'd10, 32'd0, 5'd8, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    STALL = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_res",   EX_ALU_RESULT, 32'd5);
      chk("stall_rd",    {27'h0, EX_RD}, 32'd7);
      chk("stall_valid", {31'h0, EX_VALID}, 32'h1);
    end
    STALL = 1'b0;
    tick();
    chk("post_stall_res", EX_ALU_RESULT, 32'd20);
    chk("post_stall_rd",  {27'h0, EX_RD}, 32'd8);

    drive(OP_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    idle();
    tick();
    chk("flush_valid", {31'h0, EX_VALID}, 32'h0);
    chk("flush_mw",    {31'h0, EX_MEM_WRITE}, 32'h0);

    drive(OP_ADD, 1'b0, 32'd3, 32'd4, 32'd0, 5'd9, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    drive(OP_ADD, 1'b0, 32'd6, 32'd6, 32'd0, 5'd10, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    drive(OP_XOR, 1'b0, 32'hAAAA_0000, 32'd1, 32'd0, 5'd11, 1'b1, 1'b1, 2'b00, 2'b00);
    STALL = 1'b1;
    FLUSH = 1'b1;
    tick();
    chk("sf_res",   EX_ALU_RESULT, 32'd7);
    chk("sf_rd",    {27'h0, EX_RD}, 32'd9);
    chk("sf_valid", {31'h0, EX_VALID}, 32'h1);
    STALL = 1'b0;
    FLUSH = 1'b0;
    idle();
    tick();
    chk("sf_after_res",   EX_ALU_RESULT, 32'd12);
    chk("sf_after_rd",    {27'h0, EX_RD}, 32'd10);
    chk("sf_after_valid", {31'h0, EX_VALID}, 32'h1);

    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #10;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
